// File: rtl/avalon_packetizer_pkg.sv
// Shared types and width helpers for the Avalon-ST packetizer.
// The hold register struct is sized for the widest supported beat and index.
package avalon_packetizer_pkg;

    localparam int STATS_W     = 16;
    localparam int HOLD_DATA_W = 512;
    localparam int HOLD_IDX_W  = 16;

    typedef struct packed {
        logic [HOLD_DATA_W-1:0] data;
        logic [HOLD_IDX_W-1:0]  idx;
        logic                   final_beat;
        logic                   full;
    } hold_t;

    function automatic int idx_width(input int max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

    function automatic int idle_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int empty_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat interface: source drives data/vld/sop/eop/empty, sink drives rdy.
// A beat transfers on a rising edge where vld && rdy; the source holds all fields stable while vld && !rdy.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 1
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             vld;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport source (output data, vld, sop, eop, empty, input rdy);
    modport sink   (input data, vld, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_out_reg.sv
// Registered Avalon-ST source slice: loads a beat when the slot is free and holds it under backpressure.
// The caller must only assert load while o_free is high.
module avalon_st_out_reg #(
    parameter int DATA_W  = 8,
    parameter int EMPTY_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_sop,
    input  logic               load_eop,
    input  logic [EMPTY_W-1:0] load_empty,
    input  logic               rdy,
    output logic               vld,
    output logic [DATA_W-1:0]  data,
    output logic               sop,
    output logic               eop,
    output logic [EMPTY_W-1:0] empty,
    output logic               o_free
);

    assign o_free = !vld || rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld   <= 1'b0;
            data  <= '0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            empty <= '0;
        end else if (load) begin
            vld   <= 1'b1;
            data  <= load_data;
            sop   <= load_sop;
            eop   <= load_eop;
            empty <= load_empty;
        end else if (rdy) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/avalon_packetizer.sv
// Reframes a raw Avalon-ST beat stream into packets of up to MAX_PKT_BEATS beats, closing early on input idle.
// Optional statistics ports are enabled with AVALON_PACKETIZER_STATS_EN.
module avalon_packetizer
    import avalon_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 1,
    parameter int MAX_PKT_BEATS       = 4,
    parameter int IDLE_TIMEOUT        = 8
) (
    input  logic               clk,
    input  logic               rst,
    avalon_st_if.sink          msg_in,
    avalon_st_if.source        msg_out
`ifdef AVALON_PACKETIZER_STATS_EN
    ,
    output logic [STATS_W-1:0] pkt_count,
    output logic [STATS_W-1:0] flush_count
`endif
);

    localparam int DW      = 8 * DATA_WIDTH_IN_BYTES;
    localparam int IDX_W   = idx_width(MAX_PKT_BEATS);
    localparam int IDLE_W  = idle_width(IDLE_TIMEOUT);
    localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MAX_PKT_BEATS - 1);
    localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(IDLE_TIMEOUT);

    hold_t               hold;
    logic [IDX_W-1:0]    idx_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_next;
    logic [DW-1:0]       in_data;
    logic                o_free;
    logic                in_rdy;
    logic                accept;
    logic                move;
    logic                idle_tick;
    logic                timeout_hit;

    logic                o_vld;
    logic [DW-1:0]       o_data;
    logic                o_sop;
    logic                o_eop;
    logic [EMPTY_W-1:0]  o_empty;

    assign in_data    = msg_in.data;
    assign in_rdy     = !hold.full || o_free;
    assign msg_in.rdy = in_rdy;
    assign accept     = msg_in.vld && in_rdy;

    // A held beat may only leave once its eop flag is known: either a successor
    // arrives (so it is not last) or it has already been marked final.
    assign move = hold.full && o_free && (accept || hold.final_beat);

    assign idle_tick   = hold.full && !hold.final_beat && !accept;
    assign idle_next   = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
    assign timeout_hit = idle_tick && (idle_next == TIMEOUT_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            idx_cnt  <= '0;
            idle_cnt <= '0;
        end else if (accept) begin
            hold.data       <= HOLD_DATA_W'(in_data);
            hold.idx        <= HOLD_IDX_W'(idx_cnt);
            hold.final_beat <= (idx_cnt == LAST_IDX);
            hold.full       <= 1'b1;
            idx_cnt         <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + 1'b1;
            idle_cnt        <= '0;
        end else if (move) begin
            hold.full       <= 1'b0;
            hold.final_beat <= 1'b0;
        end else if (idle_tick) begin
            idle_cnt <= idle_next;
            // Timeout closes the packet: the held beat becomes its last beat
            // and the next accepted beat starts a fresh packet.
            if (timeout_hit) begin
                hold.final_beat <= 1'b1;
                idx_cnt         <= '0;
            end
        end
    end

    avalon_st_out_reg #(
        .DATA_W  (DW),
        .EMPTY_W (EMPTY_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (move),
        .load_data  (hold.data[DW-1:0]),
        .load_sop   (hold.idx == '0),
        .load_eop   (hold.final_beat),
        .load_empty ('0),
        .rdy        (msg_out.rdy),
        .vld        (o_vld),
        .data       (o_data),
        .sop        (o_sop),
        .eop        (o_eop),
        .empty      (o_empty),
        .o_free     (o_free)
    );

    assign msg_out.vld   = o_vld;
    assign msg_out.data  = o_data;
    assign msg_out.sop   = o_sop;
    assign msg_out.eop   = o_eop;
    assign msg_out.empty = o_empty;

`ifdef AVALON_PACKETIZER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= '0;
            flush_count <= '0;
        end else begin
            if (o_vld && msg_out.rdy && o_eop && (pkt_count != '1)) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (timeout_hit && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avalon_packetizer.sv
// Self-checking bench for avalon_packetizer with MAX_PKT_BEATS=4, IDLE_TIMEOUT=3.
// Expected beats are queued as {data, sop, eop} when driven and compared against observed transfers.
module tb_avalon_packetizer;

    localparam int W    = 10;
    localparam int IDLE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_t_q[$];

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) msg_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) msg_out ();

`ifdef AVALON_PACKETIZER_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] flush_count;
`endif

    avalon_packetizer #(
        .DATA_WIDTH_IN_BYTES (1),
        .MAX_PKT_BEATS       (4),
        .IDLE_TIMEOUT        (IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .msg_in      (msg_in),
        .msg_out     (msg_out)
`ifdef AVALON_PACKETIZER_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .flush_count (flush_count)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    // output monitor: records each transfer and the edge that loaded it
    always @(negedge clk) begin
        if (!rst && msg_out.vld && msg_out.rdy) begin
            got_q.push_back({msg_out.data, msg_out.sop, msg_out.eop});
            got_t_q.push_back(cyc);
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        msg_in.vld  = 1'b0;
        msg_out.rdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_t_q.delete();
    endtask

    task automatic drive_beat(input logic [7:0] d);
        int n;
        msg_in.vld   = 1'b1;
        msg_in.data  = d;
        msg_in.sop   = 1'($urandom_range(0, 1));
        msg_in.eop   = 1'($urandom_range(0, 1));
        msg_in.empty = 1'($urandom_range(0, 1));
        n = 0;
        forever begin
            @(negedge clk);
            if (msg_in.rdy || n > 200) break;
            n++;
        end
        checks++;
        if (n > 200) begin
            errors++;
            $display("FAIL accept_timeout: beat %h not accepted after %0d cycles, required acceptance", d, n);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    // scenarios
    task automatic test_reset();
        msg_in.vld = 1'b0; msg_in.data = '0; msg_in.sop = 1'b0;
        msg_in.eop = 1'b0; msg_in.empty = '0; msg_out.rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (msg_out.vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b, expected 0", msg_out.vld); end
        checks++;
        if ({msg_out.sop, msg_out.eop} !== 2'b00) begin errors++; $display("FAIL reset_sop_eop: got %b, expected 00", {msg_out.sop, msg_out.eop}); end
        checks++;
        if (msg_out.data !== 8'h00 || msg_out.empty !== 1'b0) begin
            errors++; $display("FAIL reset_data_empty: got data=%h empty=%b, expected 00/0", msg_out.data, msg_out.empty);
        end
        checks++;
        if (msg_in.rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b, expected 1", msg_in.rdy); end
`ifdef AVALON_PACKETIZER_STATS_EN
        checks++;
        if (pkt_count !== 16'd0 || flush_count !== 16'd0) begin
            errors++; $display("FAIL reset_stats: got pkt=%0d flush=%0d, expected 0/0", pkt_count, flush_count);
        end
`endif
    endtask

    task automatic test_continuous();
        logic [W-1:0] e, g;
        int t, acc_first, acc_last;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({8'(i + 1), (i % 4 == 0), (i % 4 == 3)});
            drive_beat(8'(i + 1));
            if (i == 0) acc_first = acc_cyc;
        end
        acc_last = acc_cyc;
        msg_in.vld = 1'b0;
        checks++;
        if (acc_last - acc_first != 7) begin errors++; $display("FAIL cont_throughput: 8 beats took %0d edges, expected 7", acc_last - acc_first); end
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL cont_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL cont_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
            if (e[9:2] == 8'h08) begin
                checks++;
                if (t != acc_last + 1) begin errors++; $display("FAIL cont_last_latency: 0x08 loaded at edge %0d, expected %0d", t, acc_last + 1); end
            end
        end
    endtask

    task automatic test_partial_idle();
        logic [W-1:0] e, g;
        int t, acc_bb;
        do_reset();
        exp_q.push_back({8'hAA, 1'b1, 1'b0});
        drive_beat(8'hAA);
        exp_q.push_back({8'hBB, 1'b0, 1'b1});
        drive_beat(8'hBB);
        acc_bb = acc_cyc;
        msg_in.vld = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL idle_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL idle_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
            if (e[9:2] == 8'hBB) begin
                checks++;
                if (t != acc_bb + IDLE + 1) begin errors++; $display("FAIL idle_latency: 0xBB loaded at edge %0d, expected %0d", t, acc_bb + IDLE + 1); end
            end
        end
`ifdef AVALON_PACKETIZER_STATS_EN
        checks++;
        if (flush_count !== 16'd1 || pkt_count !== 16'd1) begin
            errors++; $display("FAIL idle_stats: got pkt=%0d flush=%0d, expected 1/1", pkt_count, flush_count);
        end
`endif
    endtask

    task automatic test_toggle_backpressure();
        logic [W-1:0] e, g;
        int t;
        do_reset();
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(posedge clk); #1;
                    msg_out.rdy = ~msg_out.rdy;
                end
                msg_out.rdy = 1'b1;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    exp_q.push_back({8'(8'h11 + i), (i == 0 || i == 4), (i == 3 || i == 5)});
                    drive_beat(8'(8'h11 + i));
                end
                msg_in.vld = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    checks++;
                    if (!msg_in.rdy && !(msg_out.vld && !msg_out.rdy)) begin
                        errors++; $display("FAIL toggle_in_rdy: got in_rdy=0 with out vld=%b rdy=%b, expected 1", msg_out.vld, msg_out.rdy);
                    end
                end
            end
        join
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL toggle_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL toggle_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
        end
    endtask

    task automatic test_timeout_stall();
        logic [W-1:0] e, g;
        int t;
        do_reset();
        exp_q.push_back({8'hAA, 1'b1, 1'b0});
        drive_beat(8'hAA);
        exp_q.push_back({8'hBB, 1'b0, 1'b1});
        drive_beat(8'hBB);
        msg_out.rdy = 1'b0;
        msg_in.vld  = 1'b0;
        fork
            begin
                repeat (10) @(posedge clk);
                #1;
                msg_out.rdy = 1'b1;
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                checks++;
                if (!(msg_out.vld === 1'b1 && msg_out.data === 8'hAA && msg_in.rdy === 1'b0)) begin
                    errors++; $display("FAIL stall_hold: got vld=%b data=%h in_rdy=%b, expected 1/AA/0", msg_out.vld, msg_out.data, msg_in.rdy);
                end
                exp_q.push_back({8'hCC, 1'b1, 1'b1});
                drive_beat(8'hCC);
                msg_in.vld = 1'b0;
            end
        join
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stall_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
        end
`ifdef AVALON_PACKETIZER_STATS_EN
        checks++;
        if (flush_count !== 16'd2 || pkt_count !== 16'd2) begin
            errors++; $display("FAIL stall_stats: got pkt=%0d flush=%0d, expected 2/2", pkt_count, flush_count);
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        logic [W-1:0] e, g;
        int t;
        do_reset();
        drive_beat(8'hCC);
        msg_in.vld = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (msg_out.vld !== 1'b0 || msg_in.rdy !== 1'b1) begin
            errors++; $display("FAIL midrst_state: got out_vld=%b in_rdy=%b, expected 0/1", msg_out.vld, msg_in.rdy);
        end
        exp_q.push_back({8'hDD, 1'b1, 1'b1});
        drive_beat(8'hDD);
        msg_in.vld = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL midrst_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e, g;
        int t, acc_34;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({8'(8'h31 + i), (i == 0 || i == 4), (i == 3 || i == 4)});
            drive_beat(8'(8'h31 + i));
            if (i == 3) acc_34 = acc_cyc;
        end
        msg_in.vld = 1'b0;
        checks++;
        if (!(msg_out.vld === 1'b1 && msg_out.data === 8'h34 && msg_out.eop === 1'b1)) begin
            errors++; $display("FAIL b2b_same_edge: got vld=%b data=%h eop=%b, expected 1/34/1", msg_out.vld, msg_out.data, msg_out.eop);
        end
`ifdef AVALON_PACKETIZER_STATS_EN
        @(posedge clk); #1;
        checks++;
        if (pkt_count !== 16'd1) begin errors++; $display("FAIL b2b_pkt_step: got pkt=%0d, expected 1", pkt_count); end
`endif
        for (int c = 0; c < 100 && got_q.size() < exp_q.size(); c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d beats, expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); t = got_t_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_beat: got data=%h sop=%b eop=%b, expected data=%h sop=%b eop=%b", g[9:2], g[1], g[0], e[9:2], e[1], e[0]); end
            if (e[9:2] == 8'h34) begin
                checks++;
                if (t != acc_34 + 1) begin errors++; $display("FAIL b2b_latency: 0x34 loaded at edge %0d, expected %0d", t, acc_34 + 1); end
            end
        end
`ifdef AVALON_PACKETIZER_STATS_EN
        checks++;
        if (pkt_count !== 16'd2) begin errors++; $display("FAIL b2b_pkt_total: got pkt=%0d, expected 2", pkt_count); end
`endif
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_continuous();
        test_partial_idle();
        test_toggle_backpressure();
        test_timeout_stall();
        test_reset_mid_packet();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
